// File: rtl/mm_bus_responder_pkg.sv
// Shared types for the main-memory bus responder: request address layout,
// MESI fill states and the bus FSM encoding.
package mm_bus_responder_pkg;

  typedef struct packed {
    logic [15:0] Page_reference;
    logic [15:0] Index;
  } Taddress;

  typedef enum logic [1:0] {MOD, EXC, SHR, INV} Tmesi_state;

  typedef enum logic [2:0] {
    IDLE, GRANT, CAPTURE, SNOOP, ACCESS, DONE, RELEASE
  } Tbus_state;

  // Pointer/index width that stays legal for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_bus_responder_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i wins, wrapping to index 0.
module rr_arbiter #(
  parameter int N_CPU = 2,
  parameter int PW    = 1
) (
  input  logic [N_CPU-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_CPU-1:0] gnt_o,
  output logic [PW-1:0]    idx_o
);

  logic found;

  // Two passes keep every select on a loop constant: upper segment, then wrap.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int j = 0; j < N_CPU; j++) begin
      if (!found && req_i[j] && (j >= int'(ptr_i))) begin
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N_CPU; j++) begin
      if (!found && req_i[j] && (j < int'(ptr_i))) begin
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_bus_responder.sv
// Main-memory responder: grants one CPU at a time, services a read or write
// against an internal word memory and returns data plus the MESI fill state.
module mm_bus_responder
  import mm_bus_responder_pkg::*;
#(
  parameter int N_CPU   = 2,
  parameter int MEM_AW  = 10,
  parameter int MEM_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CPU-1:0]       req_CPU,
  input  Taddress [N_CPU-1:0]    addr_from_program,
  input  logic [N_CPU-1:0]       we_to_mm,
  input  logic [N_CPU-1:0][31:0] wdata_to_memory,
  input  logic [N_CPU-1:0]       snoop_hit,
  output logic [N_CPU-1:0]       gnt_CPU,
  output logic [31:0]            data_from_memory,
  output Taddress                addr_from_memory,
  output Tmesi_state             rd_mesi_state,
  output logic                   read_mm_completed
);

  localparam int PW = ptr_w(N_CPU);
  localparam int CW = $clog2(MEM_LAT + 1);

  Tbus_state         state_q;
  logic [N_CPU-1:0]  gnt_q;
  logic [PW-1:0]     ptr_q, w_q, ptr_nxt;
  Taddress           addr_q, raddr_q;
  logic              we_q, shared_q, done_q;
  logic [31:0]       wdata_q, rdata_q;
  Tmesi_state        mesi_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       mem_q [2**MEM_AW];

  logic [N_CPU-1:0]  arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic [MEM_AW-1:0] idx;

  rr_arbiter #(.N_CPU(N_CPU), .PW(PW)) u_arb (
    .req_i (req_CPU),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign idx     = addr_q[MEM_AW-1:0];
  assign ptr_nxt = (w_q == PW'(N_CPU - 1)) ? '0 : w_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      w_q      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      shared_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      raddr_q  <= '0;
      mesi_q   <= INV;
    end else begin
      case (state_q)
        IDLE: if (|req_CPU) begin
          gnt_q   <= arb_gnt;
          w_q     <= arb_idx;
          state_q <= GRANT;
        end
        // Requester walked away before we captured anything: give the slot up.
        GRANT: if (!req_CPU[w_q]) begin
          gnt_q   <= '0;
          ptr_q   <= ptr_nxt;
          state_q <= IDLE;
        end else begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          addr_q  <= addr_from_program[w_q];
          we_q    <= we_to_mm[w_q];
          wdata_q <= wdata_to_memory[w_q];
          state_q <= SNOOP;
        end
        // The one-hot grant masks the requester's own snoop bit.
        SNOOP: begin
          shared_q <= |(snoop_hit & ~gnt_q);
          cnt_q    <= '0;
          state_q  <= ACCESS;
        end
        ACCESS: if (cnt_q == CW'(MEM_LAT - 1)) begin
          done_q  <= 1'b1;
          raddr_q <= addr_q;
          rdata_q <= we_q ? wdata_q : mem_q[idx];
          mesi_q  <= we_q ? MOD : (shared_q ? SHR : EXC);
          state_q <= DONE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= RELEASE;
        end
        RELEASE: if (!req_CPU[w_q]) begin
          gnt_q   <= '0;
          ptr_q   <= ptr_nxt;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory has no reset; a write lands at the end of the first ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && cnt_q == '0 && we_q)
      mem_q[idx] <= wdata_q;
  end

  assign gnt_CPU           = gnt_q;
  assign data_from_memory  = rdata_q;
  assign addr_from_memory  = raddr_q;
  assign rd_mesi_state     = mesi_q;
  assign read_mm_completed = done_q;

endmodule

// File: tb/tb_mm_bus_responder.sv
// Directed bench for mm_bus_responder: a transaction-level memory/MESI model
// checks every completion and the held outputs on each cycle.
module tb_mm_bus_responder;
  import mm_bus_responder_pkg::*;

  localparam int N_CPU   = 2;
  localparam int MEM_AW  = 10;
  localparam int MEM_LAT = 3;
  localparam int LAT_EXP = 3 + MEM_LAT;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req_CPU = '0;
  Taddress [1:0]    addr_from_program = '0;
  logic [1:0]       we_to_mm = '0;
  logic [1:0][31:0] wdata_to_memory = '0;
  logic [1:0]       snoop_hit = '0;
  logic [1:0]       gnt_CPU;
  logic [31:0]      data_from_memory;
  Taddress          addr_from_memory;
  Tmesi_state       rd_mesi_state;
  logic             read_mm_completed;

  int checks = 0;
  int fails  = 0;

  mm_bus_responder #(.N_CPU(N_CPU), .MEM_AW(MEM_AW), .MEM_LAT(MEM_LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_CPU           (req_CPU),
    .addr_from_program (addr_from_program),
    .we_to_mm          (we_to_mm),
    .wdata_to_memory   (wdata_to_memory),
    .snoop_hit         (snoop_hit),
    .gnt_CPU           (gnt_CPU),
    .data_from_memory  (data_from_memory),
    .addr_from_memory  (addr_from_memory),
    .rd_mesi_state     (rd_mesi_state),
    .read_mm_completed (read_mm_completed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- model + compare ----------------
  bit [31:0]  model_mem [1024];
  int         exp_gnt[$];
  int         cyc = 0, rise_cyc = 0, npulse = 0;
  bit         pend = 0, pc = 0, rst_smp = 1, shared;
  logic [1:0] prev_gnt = '0;
  logic [31:0] last_d = '0, last_a = '0, ea;
  Tmesi_state last_m = INV;
  int         widx;

  always @(posedge clk) rst_smp = reset;

  always @(negedge clk) begin
    cyc++;
    if (rst_smp) begin
      pend   = 0;
      last_d = '0;
      last_a = '0;
      last_m = INV;
      chk("rst_gnt", 32'(gnt_CPU), 32'd0);
      chk("rst_pulse", 32'(read_mm_completed), 32'd0);
    end else begin
      chk("gnt_onehot0", 32'($onehot0(gnt_CPU)), 32'd1);
      if (gnt_CPU != '0 && prev_gnt == '0) begin
        if (exp_gnt.size() == 0) begin
          chk("unexpected_grant", 32'(gnt_CPU), 32'd0);
        end else begin
          widx = exp_gnt.pop_front();
          chk("grant_winner", 32'(gnt_CPU), 32'(1) << widx);
        end
        rise_cyc = cyc;
        pend     = 1;
        pc       = gnt_CPU[1];
      end
      if (gnt_CPU == '0 && prev_gnt != '0) pend = 0;
      if (read_mm_completed) begin
        npulse++;
        if (!pend) begin
          chk("spurious_pulse", 32'(read_mm_completed), 32'd0);
        end else begin
          chk("latency", 32'(cyc - rise_cyc), 32'(LAT_EXP));
          ea     = addr_from_program[pc];
          last_a = ea;
          if (we_to_mm[pc]) begin
            last_d = wdata_to_memory[pc];
            last_m = MOD;
            model_mem[ea[15:0] % 1024] = wdata_to_memory[pc];
          end else begin
            shared = 0;
            for (int j = 0; j < N_CPU; j++)
              if (j != int'(pc) && snoop_hit[j]) shared = 1;
            last_d = model_mem[ea[15:0] % 1024];
            last_m = shared ? SHR : EXC;
          end
          pend = 0;
        end
      end
    end
    chk("data_out", data_from_memory, last_d);
    chk("addr_out", addr_from_memory, last_a);
    chk("mesi_out", 32'(rd_mesi_state), 32'(last_m));
    prev_gnt = gnt_CPU;
  end

  // ---------------- stimulus ----------------
  task automatic do_txn(input bit c, input bit w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    addr_from_program[c] = a;
    we_to_mm[c]          = w;
    wdata_to_memory[c]   = d;
    req_CPU[c]           = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(read_mm_completed && gnt_CPU[c]) && n < 100);
    if (n >= 100) chk("txn_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_CPU[c] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input bit c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_CPU[c] && n < 100);
    if (n >= 100) chk("gnt_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // preload DEADBEEF through a CPU0 write
    exp_gnt.push_back(0);
    do_txn(0, 1, 32'hFFFF_0001, 32'hDEAD_BEEF);
    chk("preload_mesi", 32'(rd_mesi_state), 32'(MOD));

    // read miss
    exp_gnt.push_back(0);
    do_txn(0, 0, 32'hFFFF_0001, 32'h0);
    chk("readmiss_data", data_from_memory, 32'hDEAD_BEEF);
    chk("readmiss_mesi", 32'(rd_mesi_state), 32'(EXC));
    chk("readmiss_addr", addr_from_memory, 32'hFFFF_0001);

    // shared read, then own snoop bit only
    snoop_hit = 2'b10;
    exp_gnt.push_back(0);
    do_txn(0, 0, 32'hFFFF_0001, 32'h0);
    chk("shared_mesi", 32'(rd_mesi_state), 32'(SHR));
    snoop_hit = 2'b01;
    exp_gnt.push_back(0);
    do_txn(0, 0, 32'hFFFF_0001, 32'h0);
    chk("ownbit_mesi", 32'(rd_mesi_state), 32'(EXC));
    snoop_hit = 2'b00;

    // write then read
    exp_gnt.push_back(1);
    do_txn(1, 1, 32'h0000_0042, 32'h1234_5678);
    chk("write_mesi", 32'(rd_mesi_state), 32'(MOD));
    chk("write_data", data_from_memory, 32'h1234_5678);
    exp_gnt.push_back(0);
    do_txn(0, 0, 32'h0000_0042, 32'h0);
    chk("wr_rd_data", data_from_memory, 32'h1234_5678);
    exp_gnt.push_back(1);
    do_txn(1, 0, 32'h0000_0042, 32'h0);

    // contention from ptr=0: order 0,1,0,1
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      begin do_txn(0, 0, 32'hFFFF_0001, 0); do_txn(0, 0, 32'h0000_0042, 0); end
      begin do_txn(1, 0, 32'h0000_0042, 0); do_txn(1, 0, 32'hFFFF_0001, 0); end
    join
    chk("contend_order_left", 32'(exp_gnt.size()), 32'd0);

    // reset during first ACCESS cycle of a write: write lost
    addr_from_program[1] = 32'h0000_0042;
    we_to_mm[1]          = 1'b1;
    wdata_to_memory[1]   = 32'hBAD0_BAD0;
    req_CPU[1]           = 1'b1;
    exp_gnt.push_back(1);
    wait_gnt(1);
    p0 = npulse;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    req_CPU[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_abort_no_pulse", 32'(npulse - p0), 32'd0);
    chk("rst_data", data_from_memory, 32'd0);
    chk("rst_mesi", 32'(rd_mesi_state), 32'(INV));
    exp_gnt.push_back(0);
    do_txn(0, 0, 32'h0000_0042, 32'h0);
    chk("rst_mem_kept", data_from_memory, 32'h1234_5678);

    // drop in GRANT: no pulse, ptr advances past CPU1
    addr_from_program[1] = 32'h0000_0042;
    we_to_mm[1]          = 1'b0;
    req_CPU[1]           = 1'b1;
    exp_gnt.push_back(1);
    wait_gnt(1);
    p0 = npulse;
    req_CPU[1] = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("drop_no_pulse", 32'(npulse - p0), 32'd0);
    chk("drop_gnt_low", 32'(gnt_CPU), 32'd0);
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      do_txn(0, 0, 32'hFFFF_0001, 0);
      do_txn(1, 0, 32'h0000_0042, 0);
    join

    // address wrap: Index 0x0400 aliases word 0
    exp_gnt.push_back(0);
    do_txn(0, 1, 32'h0000_0400, 32'hCAFE_F00D);
    exp_gnt.push_back(1);
    do_txn(1, 0, 32'h0000_0000, 32'h0);
    chk("wrap_data", data_from_memory, 32'hCAFE_F00D);
    chk("wrap_mesi", 32'(rd_mesi_state), 32'(EXC));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
